pi_txn_queue: RTL and testbench

//  Pi-side front end for the 68K bus cycle engine. Samples the Pi GPIO register

---
 rtl/pi_txn_queue.sv | 160 ++++++++++++++++
 tb/tb_pi_txn_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pi_txn_queue.sv
// Pi register front end: synchronizes Pi strobes, builds bus transactions from
// ADDR_LO/DATA/ADDR_HI writes, queues them and hands them one by one to the bus engine.
module pi_txn_queue #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        M68K_CLK,
    input  logic        M68K_RESET_n,
    input  logic [1:0]  PI_A,
    input  logic        PI_WR,
    input  logic        PI_RD,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_TXN_IN_PROGRESS,
    output logic        TXN_VALID,
    output logic [22:0] TXN_A,
    output logic        TXN_A0,
    output logic        TXN_SZ,
    output logic        TXN_RW,
    output logic [15:0] TXN_WDATA,
    input  logic        TXN_DONE,
    input  logic [15:0] TXN_RDATA,
    input  logic        FLUSH,
    output logic        ST_RESET_OUT,
    output logic        OVERFLOW
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 42;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] wr_sync, rd_sync;
    logic                   wr_prev, rd_prev;
    logic                   wr_evt;
    logic                   unused_rd_evt;

    logic [14:0]   stg_a;
    logic          stg_a0;
    logic [15:0]   stg_wdata;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          commit, pop, push;
    logic          in_prog, st_reset, overflow;
    logic [15:0]   rdata;

    always_ff @(posedge M68K_CLK) begin
        if (!M68K_RESET_n) begin
            wr_sync <= '0;
            rd_sync <= '0;
            wr_prev <= 1'b0;
            rd_prev <= 1'b0;
        end else begin
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], PI_WR};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], PI_RD};
            wr_prev <= wr_sync[SYNC_STAGES-1];
            rd_prev <= rd_sync[SYNC_STAGES-1];
        end
    end

    // Reads are served combinationally from PI_A; the read event has no side effect.
    assign wr_evt        = wr_sync[SYNC_STAGES-1] & ~wr_prev;
    assign unused_rd_evt = rd_sync[SYNC_STAGES-1] & ~rd_prev;

    assign commit = wr_evt && (PI_A == 2'd2);
    assign pop    = (state == ISSUE) && TXN_DONE && !FLUSH;
    // At full, a simultaneous pop frees the slot before the commit lands.
    assign push   = commit && !FLUSH && ((count != FULL_CNT) || pop);

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (FLUSH) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            if (state == IDLE) begin
                if (count != '0) state_nxt = ISSUE;
            end else if (TXN_DONE) begin
                state_nxt = IDLE;
            end
            if (push && !pop)      count_nxt = count + 1'b1;
            else if (pop && !push) count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge M68K_CLK) begin
        if (!M68K_RESET_n) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            in_prog   <= 1'b0;
            st_reset  <= 1'b1;
            overflow  <= 1'b0;
            rdata     <= '0;
            stg_a     <= '0;
            stg_a0    <= 1'b0;
            stg_wdata <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            in_prog <= (count_nxt != '0) || (state_nxt == ISSUE);
            if (FLUSH) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push) wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit && !FLUSH && !push) overflow <= 1'b1;
            if (pop && head[16]) rdata <= TXN_RDATA;
            if (wr_evt) begin
                case (PI_A)
                    2'd0: stg_wdata <= PI_D_IN;
                    2'd1: begin
                        stg_a  <= PI_D_IN[15:1];
                        stg_a0 <= PI_D_IN[0];
                    end
                    2'd3: begin
                        st_reset <= ~PI_D_IN[1];
                        if (PI_D_IN[2]) overflow <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Entry layout: {addr[22:0], a0, sz, rw, wdata[15:0]}
    always_ff @(posedge M68K_CLK) begin
        if (push) mem[wr_ptr] <= {PI_D_IN[7:0], stg_a, stg_a0, PI_D_IN[8], PI_D_IN[9], stg_wdata};
    end

    assign head      = mem[rd_ptr];
    assign TXN_VALID = (state == ISSUE);
    assign TXN_A     = head[41:19];
    assign TXN_A0    = head[18];
    assign TXN_SZ    = head[17];
    assign TXN_RW    = head[16];
    assign TXN_WDATA = head[15:0];

    assign PI_TXN_IN_PROGRESS = in_prog;
    assign ST_RESET_OUT       = st_reset;
    assign OVERFLOW           = overflow;

    always_comb begin
        PI_D_OUT = '0;
        case (PI_A)
            2'd0:    PI_D_OUT = rdata;
            2'd3:    PI_D_OUT = {overflow, count != '0, 12'd0, ~st_reset, 1'b0};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pi_txn_queue.sv
// Directed bench for pi_txn_queue: Pi register writes, dispatch handshake,
// overflow, simultaneous commit/pop, reset and flush behaviour.
module tb_pi_txn_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pi_a;
    logic        pi_wr, pi_rd;
    logic [15:0] pi_d_in, pi_d_out;
    logic        in_prog, txn_valid, txn_a0, txn_sz, txn_rw;
    logic [22:0] txn_a;
    logic [15:0] txn_wdata, txn_rdata;
    logic        txn_done, flush, st_reset_out, overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    pi_txn_queue #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .M68K_CLK           (clk),
        .M68K_RESET_n       (rst_n),
        .PI_A               (pi_a),
        .PI_WR              (pi_wr),
        .PI_RD              (pi_rd),
        .PI_D_IN            (pi_d_in),
        .PI_D_OUT           (pi_d_out),
        .PI_TXN_IN_PROGRESS (in_prog),
        .TXN_VALID          (txn_valid),
        .TXN_A              (txn_a),
        .TXN_A0             (txn_a0),
        .TXN_SZ             (txn_sz),
        .TXN_RW             (txn_rw),
        .TXN_WDATA          (txn_wdata),
        .TXN_DONE           (txn_done),
        .TXN_RDATA          (txn_rdata),
        .FLUSH              (flush),
        .ST_RESET_OUT       (st_reset_out),
        .OVERFLOW           (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe held three cycles: two sync flops plus the event cycle; commit lands on the third edge.
    task automatic wr_start(input logic [1:0] a, input logic [15:0] d);
        pi_a = a; pi_d_in = d; pi_wr = 1'b1;
        repeat (3) tick();
    endtask

    task automatic wr_end();
        pi_wr = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        wr_start(a, d);
        wr_end();
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
        pi_a = a;
        #1;
        v = pi_d_out;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20 && !txn_valid; k++) tick();
        chk(tag, txn_valid, 1'b1);
    endtask

    task automatic done_pulse(input logic [15:0] r);
        txn_done = 1'b1; txn_rdata = r;
        tick();
        txn_done = 1'b0;
    endtask

    logic [15:0] v;

    initial begin
        rst_n = 1'b0; pi_a = 2'd0; pi_wr = 1'b0; pi_rd = 1'b0; pi_d_in = '0;
        txn_done = 1'b0; txn_rdata = '0; flush = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_valid", txn_valid, 1'b0);
        chk("rst_inprog", in_prog, 1'b0);
        chk("rst_st_reset", st_reset_out, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        rd_reg(2'd3, v); chk("rst_status", v, 16'h0000);
        rd_reg(2'd0, v); chk("rst_rdata", v, 16'h0000);
        rst_n = 1'b1;
        tick();

        // single write with minimum latency
        pi_rd = 1'b1; tick(); pi_rd = 1'b0;
        pi_write(2'd1, 16'h1234);
        pi_write(2'd0, 16'hBEEF);
        wr_start(2'd2, 16'h0000);
        chk("w_commit_valid", txn_valid, 1'b0);
        chk("w_commit_inprog", in_prog, 1'b1);
        tick();
        chk("w_valid", txn_valid, 1'b1);
        chk("w_a", txn_a, 23'h00091A);
        chk("w_a0", txn_a0, 1'b0);
        chk("w_sz", txn_sz, 1'b0);
        chk("w_rw", txn_rw, 1'b0);
        chk("w_wdata", txn_wdata, 16'hBEEF);
        wr_end();
        chk("w_valid_held", txn_valid, 1'b1);
        done_pulse(16'h1111);
        chk("w_done_valid", txn_valid, 1'b0);
        chk("w_done_inprog", in_prog, 1'b0);
        rd_reg(2'd0, v); chk("w_rdata_kept", v, 16'h0000);

        // read transaction
        pi_write(2'd2, 16'h0200);
        wait_valid("r_valid");
        chk("r_rw", txn_rw, 1'b1);
        chk("r_a", txn_a, 23'h00091A);
        done_pulse(16'hA5A5);
        chk("r_inprog", in_prog, 1'b0);
        chk("r_valid_low", txn_valid, 1'b0);
        rd_reg(2'd0, v); chk("r_rdata", v, 16'hA5A5);

        // overflow: five commits, four fit
        for (int i = 0; i < 5; i++) begin
            pi_write(2'd1, 16'h0100 + 16'(2 * i));
            pi_write(2'd0, 16'h1000 + 16'(i));
            pi_write(2'd2, 16'h0000);
        end
        chk("ov_flag", overflow, 1'b1);
        rd_reg(2'd3, v); chk("ov_status", v, 16'hC000);
        for (int i = 0; i < 4; i++) begin
            wait_valid("ov_issue_valid");
            chk("ov_issue_a", txn_a, 23'h80 + 23'(i));
            chk("ov_issue_wdata", txn_wdata, 16'h1000 + 16'(i));
            done_pulse(16'h0000);
        end
        repeat (3) tick();
        chk("ov_drained_valid", txn_valid, 1'b0);
        chk("ov_drained_inprog", in_prog, 1'b0);
        pi_write(2'd3, 16'h0004);
        chk("ov_cleared", overflow, 1'b0);
        chk("ov_st_reset", st_reset_out, 1'b1);
        rd_reg(2'd3, v); chk("ov_status_clr", v, 16'h0000);

        // full queue: commit on the same edge as DONE
        for (int i = 0; i < 4; i++) begin
            pi_write(2'd1, 16'h0200 + 16'(2 * i));
            pi_write(2'd0, 16'h2000 + 16'(i));
            pi_write(2'd2, 16'h0000);
        end
        pi_write(2'd1, 16'h0208);
        pi_write(2'd0, 16'h2004);
        chk("sim_head_valid", txn_valid, 1'b1);
        chk("sim_head_a", txn_a, 23'h100);
        pi_a = 2'd2; pi_d_in = 16'h0000; pi_wr = 1'b1;
        tick(); tick();
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        wr_end();
        chk("sim_overflow", overflow, 1'b0);
        for (int i = 1; i < 5; i++) begin
            wait_valid("sim_issue_valid");
            chk("sim_issue_a", txn_a, 23'h100 + 23'(i));
            chk("sim_issue_wdata", txn_wdata, 16'h2000 + 16'(i));
            done_pulse(16'h0000);
        end
        repeat (3) tick();
        chk("sim_empty", txn_valid, 1'b0);
        chk("sim_overflow_end", overflow, 1'b0);

        // reset during ISSUE with three entries queued
        for (int i = 0; i < 3; i++) pi_write(2'd2, 16'h0000);
        wait_valid("rs_valid");
        rst_n = 1'b0;
        tick();
        chk("rs_valid_low", txn_valid, 1'b0);
        chk("rs_inprog", in_prog, 1'b0);
        chk("rs_st_reset", st_reset_out, 1'b1);
        rd_reg(2'd3, v); chk("rs_status", v, 16'h0000);
        rd_reg(2'd0, v); chk("rs_rdata", v, 16'h0000);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rs_no_valid", txn_valid, 1'b0);
        pi_write(2'd3, 16'h0002);
        chk("rs_st_release", st_reset_out, 1'b0);
        rd_reg(2'd3, v); chk("rs_status2", v, 16'h0002);

        // FLUSH coinciding with DONE
        pi_write(2'd1, 16'h0400);
        pi_write(2'd2, 16'h0200);
        wait_valid("fl_pre_valid");
        done_pulse(16'h5A5A);
        rd_reg(2'd0, v); chk("fl_pre_rdata", v, 16'h5A5A);
        pi_write(2'd2, 16'h0200);
        pi_write(2'd2, 16'h0200);
        wait_valid("fl_valid");
        flush = 1'b1; txn_done = 1'b1; txn_rdata = 16'h1234;
        tick();
        flush = 1'b0; txn_done = 1'b0;
        chk("fl_valid_low", txn_valid, 1'b0);
        chk("fl_inprog", in_prog, 1'b0);
        rd_reg(2'd0, v); chk("fl_rdata", v, 16'h5A5A);
        repeat (6) tick();
        chk("fl_no_valid", txn_valid, 1'b0);
        chk("fl_st_kept", st_reset_out, 1'b0);
        rd_reg(2'd3, v); chk("fl_status", v, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
